// File: rtl/enm_path_ctrl.sv
// enm_path_ctrl: per-enemy three-phase path controller with mirroring, pause and timed respawn.
// Ports: clk22/rst (sync, active-high) tick clock and reset; enmhp/spawn_x/spawn_y/mirror are
// packed per-enemy inputs; pause freezes motion and timers; enmx/enmy/alive/phase/kill_pulse are
// registered per-enemy outputs (phase 00=A, 01=B, 10=C, 11=DEAD).
module enm_path_ctrl #(
    parameter int N_ENM         = 4,
    parameter int XW            = 10,
    parameter int HPW           = 7,
    parameter int HP_HI         = 80,
    parameter int HP_LO         = 40,
    parameter int Y_MIN         = 20,
    parameter int Y_MAX         = 200,
    parameter int X_SPAN        = 100,
    parameter int VSTEP         = 2,
    parameter int HSTEP         = 1,
    parameter int RESPAWN_TICKS = 64
) (
    input  logic                  clk22,
    input  logic                  rst,
    input  logic [N_ENM*HPW-1:0]  enmhp,
    input  logic [N_ENM*XW-1:0]   spawn_x,
    input  logic [N_ENM*XW-1:0]   spawn_y,
    input  logic [N_ENM-1:0]      mirror,
    input  logic                  pause,
    output logic [N_ENM*XW-1:0]   enmx,
    output logic [N_ENM*XW-1:0]   enmy,
    output logic [N_ENM-1:0]      alive,
    output logic [N_ENM*2-1:0]    phase,
    output logic [N_ENM-1:0]      kill_pulse
);
    typedef enum logic [1:0] {ST_A = 2'b00, ST_B = 2'b01, ST_C = 2'b10, ST_DEAD = 2'b11} st_t;

    localparam int TW = $clog2(RESPAWN_TICKS + 1);
    localparam logic [TW-1:0]  TMAX = TW'(RESPAWN_TICKS);
    localparam logic [HPW-1:0] HI   = HPW'(HP_HI);
    localparam logic [HPW-1:0] LO   = HPW'(HP_LO);
    localparam logic [XW-1:0]  YMN  = XW'(Y_MIN);
    localparam logic [XW-1:0]  YMX  = XW'(Y_MAX);
    localparam logic [XW-1:0]  VS   = XW'(VSTEP);
    localparam logic [XW-1:0]  HS   = XW'(HSTEP);
    localparam logic [XW:0]    SPAN = (XW+1)'(X_SPAN);

    // One step of size s from p toward t, clamped to t; widened by one bit so nothing wraps.
    function automatic logic [XW-1:0] step_to(input logic [XW-1:0] p, input logic [XW-1:0] t,
                                              input logic [XW-1:0] s);
        logic [XW:0] pw, tw, sw;
        pw = {1'b0, p};
        tw = {1'b0, t};
        sw = {1'b0, s};
        if (pw < tw)      step_to = (pw + sw >= tw) ? t : p + s;
        else if (pw > tw) step_to = (pw < tw + sw) ? t : p - s;
        else              step_to = p;
    endfunction

    for (genvar i = 0; i < N_ENM; i++) begin : g_enm
        st_t              st_q, st_d, dec;
        logic [XW-1:0]    x_q, x_d, y_q, y_d, sx, sy, xb_t;
        logic [TW-1:0]    t_q, t_d;
        logic             k_q, k_d, m;
        logic [HPW-1:0]   hp;
        logic [XW:0]      sum, dif;

        assign hp  = enmhp[i*HPW +: HPW];
        assign sx  = spawn_x[i*XW +: XW];
        assign sy  = spawn_y[i*XW +: XW];
        assign m   = mirror[i];
        assign dec = (hp == '0) ? ST_DEAD : (hp > HI) ? ST_A : (hp > LO) ? ST_B : ST_C;
        // Phase B target saturates at the coordinate range edges.
        assign sum  = {1'b0, sx} + SPAN;
        assign dif  = {1'b0, sx} - SPAN;
        assign xb_t = m ? (dif[XW] ? '0 : dif[XW-1:0]) : (sum[XW] ? '1 : sum[XW-1:0]);

        always_ff @(posedge clk22) begin
            if (rst) begin
                st_q <= ST_A;
                x_q  <= sx;
                y_q  <= sy;
                t_q  <= '0;
                k_q  <= 1'b0;
            end else begin
                st_q <= st_d;
                x_q  <= x_d;
                y_q  <= y_d;
                t_q  <= t_d;
                k_q  <= k_d;
            end
        end

        always_comb begin
            st_d = st_q;
            x_d  = x_q;
            y_d  = y_q;
            t_d  = t_q;
            k_d  = 1'b0;
            if (st_q != ST_DEAD) begin
                // Death is honoured even while paused.
                if (dec == ST_DEAD) begin
                    st_d = ST_DEAD;
                    x_d  = '0;
                    y_d  = '0;
                    t_d  = '0;
                    k_d  = 1'b1;
                end else if (!pause) begin
                    st_d = dec;
                    if (dec == ST_A) begin
                        x_d = sx;
                        y_d = step_to(y_q, m ? YMN : YMX, VS);
                    end else if (dec == ST_B) begin
                        x_d = step_to(x_q, xb_t, HS);
                    end else begin
                        y_d = step_to(y_q, m ? YMX : YMN, VS);
                    end
                end
            end else if (!pause) begin
                if (t_q == TMAX && dec != ST_DEAD) begin
                    st_d = dec;
                    x_d  = sx;
                    y_d  = sy;
                end else if (t_q != TMAX) begin
                    t_d = t_q + 1'b1;
                end
            end
        end

        assign enmx[i*XW +: XW] = x_q;
        assign enmy[i*XW +: XW] = y_q;
        assign alive[i]         = (st_q != ST_DEAD);
        assign phase[i*2 +: 2]  = st_q;
        assign kill_pulse[i]    = k_q;
    end
endmodule

// File: tb/tb_enm_path_ctrl.sv
// tb_enm_path_ctrl: scoreboard bench for enm_path_ctrl against a rule-level reference model.
module tb_enm_path_ctrl;
    localparam int N = 4;
    localparam int XW = 10;
    localparam int HPW = 7;

    logic            clk22 = 1'b0;
    logic            rst = 1'b1;
    logic [N*HPW-1:0] enmhp;
    logic [N*XW-1:0] spawn_x, spawn_y, enmx, enmy;
    logic [N-1:0]    mirror, alive, kill_pulse;
    logic            pause;
    logic [N*2-1:0]  phase;

    typedef struct {
        logic [N*XW-1:0] x, y;
        logic [N-1:0]    al, k;
        logic [N*2-1:0]  ph;
    } exp_t;
    exp_t q[$];

    int checks = 0, errors = 0;
    int hp[N], sx[N], sy[N], mir[N];
    int mx[N], my[N], mt[N], mph[N], mk[N];

    enm_path_ctrl dut (
        .clk22(clk22), .rst(rst), .enmhp(enmhp), .spawn_x(spawn_x), .spawn_y(spawn_y),
        .mirror(mirror), .pause(pause), .enmx(enmx), .enmy(enmy), .alive(alive),
        .phase(phase), .kill_pulse(kill_pulse)
    );

    always #5 clk22 = ~clk22;

    function automatic int mv(int p, int t, int s);
        if (p < t) return (p + s > t) ? t : p + s;
        if (p > t) return (p - s < t) ? t : p - s;
        return p;
    endfunction

    function automatic int decode(int h);
        if (h == 0) return 3;
        if (h > 80) return 0;
        if (h > 40) return 1;
        return 2;
    endfunction

    task automatic chk(string n, logic [63:0] a, logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    // Advance the reference model by one tick using the inputs now applied, queue its outputs,
    // and move to the next falling edge.
    task automatic cyc();
        exp_t e;
        for (int i = 0; i < N; i++) begin
            enmhp[i*HPW +: HPW]  = HPW'(hp[i]);
            spawn_x[i*XW +: XW]  = XW'(sx[i]);
            spawn_y[i*XW +: XW]  = XW'(sy[i]);
            mirror[i]            = mir[i][0];
        end
        for (int i = 0; i < N; i++) begin
            int d;
            d = decode(hp[i]);
            mk[i] = 0;
            if (rst) begin
                mx[i] = sx[i]; my[i] = sy[i]; mt[i] = 0; mph[i] = 0;
            end else if (mph[i] != 3) begin
                if (d == 3) begin
                    mph[i] = 3; mx[i] = 0; my[i] = 0; mt[i] = 0; mk[i] = 1;
                end else if (!pause) begin
                    mph[i] = d;
                    if (d == 0) begin
                        mx[i] = sx[i];
                        my[i] = mv(my[i], mir[i] ? 20 : 200, 2);
                    end else if (d == 1) begin
                        int t;
                        t = mir[i] ? sx[i] - 100 : sx[i] + 100;
                        if (t < 0) t = 0;
                        if (t > 1023) t = 1023;
                        mx[i] = mv(mx[i], t, 1);
                    end else begin
                        my[i] = mv(my[i], mir[i] ? 200 : 20, 2);
                    end
                end
            end else if (!pause) begin
                if (mt[i] == 64 && hp[i] != 0) begin
                    mph[i] = d; mx[i] = sx[i]; my[i] = sy[i];
                end else if (mt[i] < 64) begin
                    mt[i]++;
                end
            end
            e.x[i*XW +: XW] = XW'(mx[i]);
            e.y[i*XW +: XW] = XW'(my[i]);
            e.al[i]         = (mph[i] != 3);
            e.k[i]          = mk[i][0];
            e.ph[i*2 +: 2]  = 2'(mph[i]);
        end
        q.push_back(e);
        @(negedge clk22);
    endtask

    initial begin
        forever begin
            @(posedge clk22);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("enmx", 64'(enmx), 64'(e.x));
                chk("enmy", 64'(enmy), 64'(e.y));
                chk("alive", 64'(alive), 64'(e.al));
                chk("phase", 64'(phase), 64'(e.ph));
                chk("kill_pulse", 64'(kill_pulse), 64'(e.k));
            end
        end
    end

    initial begin
        pause = 1'b0;
        for (int i = 0; i < N; i++) begin
            hp[i] = 100; mir[i] = 0;
            sx[i] = 60 + 50 * i; sy[i] = 30 + 10 * i;
        end
        sx[0] = 40; sy[0] = 40;
        rst = 1'b1; cyc(); rst = 1'b0;
        repeat (85) cyc();
        hp[0] = 60;  repeat (105) cyc();
        mir[0] = 1;  repeat (150) cyc();
        mir[0] = 0;  repeat (105) cyc();
        hp[0] = 30;  repeat (95) cyc();
        hp[0] = 0;   repeat (10) cyc();
        hp[0] = 127; repeat (70) cyc();
        hp[0] = 60;  repeat (5) cyc();
        pause = 1'b1; repeat (5) cyc();
        hp[2] = 0;   repeat (15) cyc();
        pause = 1'b0; hp[2] = 90; repeat (70) cyc();
        hp[0] = 0; hp[3] = 0; repeat (6) cyc();
        rst = 1'b1; cyc(); rst = 1'b0;
        for (int i = 0; i < N; i++) hp[i] = 100;
        repeat (3) cyc();
        sy[1] = 21; hp[1] = 30;
        rst = 1'b1; cyc(); rst = 1'b0;
        repeat (3) cyc();
        for (int n = 0; n < 2500; n++) begin
            int i;
            i = $urandom_range(N - 1);
            case ($urandom_range(39))
                0, 1, 2: hp[i] = 0;
                3, 4, 5, 6: hp[i] = $urandom_range(127);
                7: begin
                    int b[4] = '{40, 41, 80, 81};
                    hp[i] = b[$urandom_range(3)];
                end
                8: mir[i] = $urandom_range(1);
                9: sx[i] = ($urandom_range(1)) ? $urandom_range(1023) : ($urandom_range(1) ? $urandom_range(30) : 1000 + $urandom_range(23));
                10: sy[i] = $urandom_range(1023);
                11: pause = ($urandom_range(3) == 0);
                12: if ($urandom_range(15) == 0) rst = 1'b1;
                default: ;
            endcase
            cyc();
            rst = 1'b0;
        end
        pause = 1'b0;
        repeat (2) cyc();
        repeat (2) @(negedge clk22);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
